stream2native_mc: RTL and testbench
===================================

# stream2native_mc

Multi-channel, back-pressure-aware bridge from AXI-Stream slave ports to native-FIFO write ports, one independent lane per channel. Each lane holds a 2-entry skid buffer so that `s_axis_tready` is a registered output and native-FIFO `fifo_full` is honoured without losing or duplicating data. It sits between the router's per-lane stream inputs and the lane input FIFOs. It is the parametrised successor of the single-channel stream-to-native converter, adding a channel count, full-flag handling and per-lane write counters.

## Interface
- `DATA_WIDTH`, 256: payload width per channel.
- `NUM_CH`, 4: number of independent lanes, ≥1.
- `CNT_WIDTH`, 16: width of each per-lane write counter.

- `clk` in 1: single clock; all logic on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `s_axis_tvalid` in NUM_CH: per-lane valid.
- `s_axis_tready` out NUM_CH: per-lane ready; driven directly from a register.
- `s_axis_tdata` in NUM_CH*DATA_WIDTH: lane k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
- `fifo_full` in NUM_CH: per-lane native FIFO full flag.
- `wr_en` out NUM_CH: per-lane FIFO write strobe.
- `data_in` out NUM_CH*DATA_WIDTH: per-lane FIFO write data, same packing as `s_axis_tdata`.
- `clr_count` in 1: synchronous clear of all write counters.
- `wr_count` out NUM_CH*CNT_WIDTH: per-lane saturating count of FIFO writes.

## Operation
- Lanes are fully independent; the description below applies to each lane k.
- Accept: `s_axis_tvalid[k] & s_axis_tready[k]` at a rising edge stores the beat.
- Write: `wr_en[k] = head_valid & ~fifo_full[k]`. This is the only combinational output term. `data_in` is the head register.
- Lane state machine, `occ` = 0/1/2 (EMPTY/ONE/TWO):
  - accept and no write: `occ+1`; the new beat goes to head if EMPTY, otherwise to skid.
  - write and no accept: `occ-1`; in TWO, skid moves to head.
  - accept and write: `occ` unchanged. In ONE, the new beat loads head. In TWO this case cannot occur because ready is 0.
  - neither: hold.
- `head_valid = (occ != EMPTY)`.
- Ready register: `s_axis_tready[k] <= (occ_next != TWO)`.
- Ordering is strict FIFO. Every accepted beat is written exactly once. No beat is dropped while `fifo_full` is high.
- Counter behaviour:
  - `wr_count[k]` increments on each cycle with `wr_en[k]=1`.
  - It saturates at 2^CNT_WIDTH−1 and never wraps.
  - `clr_count=1` forces all counters to 0. Clear has priority: a write in the same cycle is not counted.
- Data behaviour:
  - `s_axis_tdata` is ignored when not accepted.
  - `data_in` holds its last value when `occ=EMPTY`; it is not required to be zero.

## Timing
- Reset (async assert, `rst_n=0`):
  - `occ`=EMPTY, `s_axis_tready`=0, `wr_en`=0, `data_in`=0, `wr_count`=0.
  - `s_axis_tready` rises to all-ones at the first rising edge after `rst_n` deasserts.
- Latency: a beat accepted at edge N is presented on `data_in` with `wr_en=1` in the cycle after edge N, provided `fifo_full=0`.
- Throughput: with `fifo_full=0` and continuous valid, the lane sits in ONE and accepts and writes one beat per cycle indefinitely.
- Backpressure:
  - `fifo_full` rising while streaming: at most one extra beat is accepted (into skid).
  - `s_axis_tready` is 0 from the next cycle until a write occurs.
- Recovery: after `fifo_full` falls, the head is written in that same cycle. `s_axis_tready` returns to 1 one cycle later.
- `fifo_full` and `s_axis_tvalid` changing in the same cycle are both evaluated against the current `occ`. No priority issue arises because accept and write are independent updates.
- Reset mid-operation: buffered beats are discarded and outputs return to reset values immediately (asynchronously). There is no partial write.

## Test plan
- Reset release, NUM_CH=4, idle inputs -> `s_axis_tready`=4'b0000 during reset, 4'b1111 one edge after release; `wr_en`=0, `wr_count`=0.
- Lane 0 streams 0x01..0x08 back-to-back, `fifo_full`=0 -> `wr_en[0]` high 8 consecutive cycles, each one cycle after its accept; `data_in` = 0x01..0x08 in order; `wr_count[0]`=8.
- Lane 1 streaming 0xA0, 0xA1, … with `fifo_full[1]` held high for 5 cycles mid-stream -> exactly 2 beats buffered; `s_axis_tready[1]`=0 while full; after release, writes resume with no gap, loss or duplicate.
- All 4 lanes driven with random valid/full patterns, 10k beats each -> per-lane scoreboard matches input order exactly; lanes never interfere.
- CNT_WIDTH=4, 20 writes on lane 2, then `clr_count` pulsed in the same cycle as a write -> `wr_count[2]` saturates at 15 and becomes 0 (not 1) after the clear.
- `rst_n` asserted while lane 3 holds 2 beats and `fifo_full[3]`=1 -> `wr_en[3]`=0 immediately; after release, no stale beat is written.

Source files
------------

// File: rtl/stream2native_mc_if.sv
// Per-lane AXI-Stream slave side and native-FIFO write side of the stream2native_mc bridge.
// The bridge uses the slave modport; the upstream/FIFO environment uses the master modport.
interface stream2native_mc_if #(
  parameter int unsigned DATA_WIDTH = 256,
  parameter int unsigned NUM_CH     = 4
);
  logic [NUM_CH-1:0]            s_axis_tvalid;
  logic [NUM_CH-1:0]            s_axis_tready;
  logic [NUM_CH*DATA_WIDTH-1:0] s_axis_tdata;
  logic [NUM_CH-1:0]            fifo_full;
  logic [NUM_CH-1:0]            wr_en;
  logic [NUM_CH*DATA_WIDTH-1:0] data_in;

  modport master (
    output s_axis_tvalid, s_axis_tdata, fifo_full,
    input  s_axis_tready, wr_en, data_in
  );

  modport slave (
    input  s_axis_tvalid, s_axis_tdata, fifo_full,
    output s_axis_tready, wr_en, data_in
  );
endinterface

// File: rtl/stream2native_mc.sv
// Multi-lane AXI-Stream to native-FIFO bridge: each lane has a 2-entry skid buffer,
// a registered tready, a full-aware write strobe and a saturating write counter.
module stream2native_mc #(
  parameter int unsigned DATA_WIDTH = 256,
  parameter int unsigned NUM_CH     = 4,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  stream2native_mc_if.slave           bus,
  input  logic                        clr_count,
  output logic [NUM_CH*CNT_WIDTH-1:0] wr_count
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } occ_e;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  logic [NUM_CH-1:0]            w_ready;
  logic [NUM_CH-1:0]            w_wr_en;
  logic [NUM_CH*DATA_WIDTH-1:0] w_data_in;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_lane
    occ_e                  r_occ;
    logic                  r_ready;
    logic [DATA_WIDTH-1:0] r_head;
    logic [DATA_WIDTH-1:0] r_skid;
    logic [CNT_WIDTH-1:0]  r_cnt;
    logic [DATA_WIDTH-1:0] w_beat;
    logic                  w_accept;
    logic                  w_write;

    assign w_beat   = bus.s_axis_tdata[k*DATA_WIDTH +: DATA_WIDTH];
    assign w_accept = bus.s_axis_tvalid[k] & r_ready;
    assign w_write  = (r_occ != EMPTY) & ~bus.fifo_full[k];

    // Occupancy FSM; tready is loaded with (next occupancy != TWO)
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_occ   <= EMPTY;
        r_ready <= 1'b0;
        r_head  <= '0;
        r_skid  <= '0;
      end else begin
        case (r_occ)
          EMPTY: begin
            r_ready <= 1'b1;
            if (w_accept) begin
              r_head <= w_beat;
              r_occ  <= ONE;
            end
          end
          ONE: begin
            if (w_accept && w_write) begin
              r_head  <= w_beat;
              r_ready <= 1'b1;
            end else if (w_accept) begin
              r_skid  <= w_beat;
              r_occ   <= TWO;
              r_ready <= 1'b0;
            end else if (w_write) begin
              r_occ   <= EMPTY;
              r_ready <= 1'b1;
            end else begin
              r_ready <= 1'b1;
            end
          end
          TWO: begin
            // tready is low here, so only a drain can happen
            if (w_write) begin
              r_head  <= r_skid;
              r_occ   <= ONE;
              r_ready <= 1'b1;
            end else begin
              r_ready <= 1'b0;
            end
          end
          default: begin
            r_occ   <= EMPTY;
            r_ready <= 1'b0;
          end
        endcase
      end
    end

    // Saturating write counter; clear wins over a same-cycle write
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_cnt <= '0;
      end else if (clr_count) begin
        r_cnt <= '0;
      end else if (w_write && (r_cnt != CNT_MAX)) begin
        r_cnt <= r_cnt + CNT_WIDTH'(1);
      end
    end

    assign w_ready[k]                              = r_ready;
    assign w_wr_en[k]                              = w_write;
    assign w_data_in[k*DATA_WIDTH +: DATA_WIDTH]   = r_head;
    assign wr_count[k*CNT_WIDTH +: CNT_WIDTH]      = r_cnt;
  end

  assign bus.s_axis_tready = w_ready;
  assign bus.wr_en         = w_wr_en;
  assign bus.data_in       = w_data_in;

endmodule

// File: tb/tb_stream2native_mc.sv
// Self-checking bench for stream2native_mc: directed vector tables, hand sequences for
// saturation and reset corners, and random traffic against a queue-based reference model.
module tb_stream2native_mc;

  localparam int unsigned DW   = 32;
  localparam int unsigned NCH  = 4;
  localparam int unsigned CW   = 4;
  localparam int          CMAX = (1 << CW) - 1;
  localparam int          NBEATS = 10000;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              clr_count;
  logic [NCH*CW-1:0] wr_count;

  stream2native_mc_if #(.DATA_WIDTH(DW), .NUM_CH(NCH)) bus ();

  stream2native_mc #(.DATA_WIDTH(DW), .NUM_CH(NCH), .CNT_WIDTH(CW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .clr_count (clr_count),
    .wr_count  (wr_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          lane;
    logic        v;
    logic [DW-1:0] d;
    logic        f;
    logic        e_rdy;
    logic        e_wr;
    logic [DW-1:0] e_d;
    int          e_cnt;
  } vec_t;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: each lane is a FIFO of at most two buffered beats
  logic [DW-1:0] mq [NCH][$];
  logic          m_rdy [NCH];
  logic          m_ew  [NCH];
  int            m_cnt [NCH];
  int            m_acc [NCH];
  int            got   [NCH];

  logic [NCH-1:0]    cur_v;
  logic [NCH*DW-1:0] cur_d;
  logic [NCH-1:0]    cur_f;
  logic              cur_clr;

  vec_t tbl[$];

  task automatic chk(input string name, input int lane, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s lane=%0d t=%0t actual=%0h required=%0h", name, lane, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < NCH; k++) begin
      mq[k].delete();
      m_rdy[k] = 1'b0;
      m_ew[k]  = 1'b0;
      m_cnt[k] = 0;
    end
  endtask

  task automatic drive(input logic [NCH-1:0] v, input logic [NCH*DW-1:0] d,
                       input logic [NCH-1:0] f, input logic clr);
    cur_v = v; cur_d = d; cur_f = f; cur_clr = clr;
    bus.s_axis_tvalid = v;
    bus.s_axis_tdata  = d;
    bus.fifo_full     = f;
    clr_count         = clr;
    #4;
  endtask

  task automatic check_model();
    for (int k = 0; k < NCH; k++) begin
      m_ew[k] = (mq[k].size() != 0) && !cur_f[k];
      chk("tready", k, 64'(bus.s_axis_tready[k]), 64'(m_rdy[k]));
      chk("wr_en", k, 64'(bus.wr_en[k]), 64'(m_ew[k]));
      if (m_ew[k]) chk("data_in", k, 64'(bus.data_in[k*DW +: DW]), 64'(mq[k][0]));
      chk("wr_count", k, 64'(wr_count[k*CW +: CW]), 64'(m_cnt[k]));
      if (bus.wr_en[k]) got[k]++;
    end
  endtask

  task automatic advance();
    @(posedge clk);
    for (int k = 0; k < NCH; k++) begin
      if (m_ew[k]) void'(mq[k].pop_front());
      if (cur_v[k] && m_rdy[k]) begin
        mq[k].push_back(cur_d[k*DW +: DW]);
        m_acc[k]++;
      end
      m_rdy[k] = (mq[k].size() != 2);
      if (cur_clr) m_cnt[k] = 0;
      else if (m_ew[k] && m_cnt[k] < CMAX) m_cnt[k]++;
    end
    #1;
  endtask

  task automatic idle_cycle();
    drive('0, '0, '0, 1'b0);
    check_model();
    advance();
  endtask

  function automatic vec_t mk(int lane, logic v, logic [DW-1:0] d, logic f,
                              logic r, logic w, logic [DW-1:0] ed, int c);
    vec_t t;
    t.lane = lane; t.v = v; t.d = d; t.f = f;
    t.e_rdy = r; t.e_wr = w; t.e_d = ed; t.e_cnt = c;
    return t;
  endfunction

  initial begin
    logic [NCH-1:0]    v;
    logic [NCH*DW-1:0] d;
    logic [NCH-1:0]    f;
    logic              done;

    rst_n = 1'b0;
    cur_v = '0; cur_d = '0; cur_f = '0; cur_clr = 1'b0;
    bus.s_axis_tvalid = '0;
    bus.s_axis_tdata  = '0;
    bus.fifo_full     = '0;
    clr_count         = 1'b0;
    model_reset();
    for (int k = 0; k < NCH; k++) begin m_acc[k] = 0; got[k] = 0; end

    // Reset state, then tready rises one edge after release
    repeat (2) @(posedge clk);
    #1;
    chk("rst_tready", -1, 64'(bus.s_axis_tready), 64'(0));
    chk("rst_wr_en", -1, 64'(bus.wr_en), 64'(0));
    chk("rst_wr_count", -1, 64'(wr_count), 64'(0));
    for (int k = 0; k < NCH; k++) chk("rst_data_in", k, 64'(bus.data_in[k*DW +: DW]), 64'(0));
    rst_n = 1'b1;
    drive('0, '0, '0, 1'b0);
    check_model();
    chk("tready_pre_edge", -1, 64'(bus.s_axis_tready), 64'(4'b0000));
    advance();
    drive('0, '0, '0, 1'b0);
    check_model();
    chk("tready_post_edge", -1, 64'(bus.s_axis_tready), 64'(4'b1111));
    advance();

    // Lane 0: 0x01..0x08 back-to-back, no backpressure
    for (int i = 0; i < 10; i++)
      tbl.push_back(mk(0, i < 8, DW'(i + 1), 1'b0, 1'b1, (i >= 1 && i <= 8), DW'(i), (i <= 1) ? 0 : i - 1));
    // Lane 1: fifo_full held for 5 cycles mid-stream
    tbl.push_back(mk(1, 1, 32'hA0, 0, 1, 0, 32'h00, 0));
    tbl.push_back(mk(1, 1, 32'hA1, 0, 1, 1, 32'hA0, 0));
    tbl.push_back(mk(1, 1, 32'hA2, 1, 1, 0, 32'h00, 1));
    tbl.push_back(mk(1, 1, 32'hA3, 1, 0, 0, 32'h00, 1));
    tbl.push_back(mk(1, 1, 32'hA3, 1, 0, 0, 32'h00, 1));
    tbl.push_back(mk(1, 1, 32'hA3, 1, 0, 0, 32'h00, 1));
    tbl.push_back(mk(1, 1, 32'hA3, 1, 0, 0, 32'h00, 1));
    tbl.push_back(mk(1, 1, 32'hA3, 0, 0, 1, 32'hA1, 1));
    tbl.push_back(mk(1, 1, 32'hA3, 0, 1, 1, 32'hA2, 2));
    tbl.push_back(mk(1, 1, 32'hA4, 0, 1, 1, 32'hA3, 3));
    tbl.push_back(mk(1, 0, 32'h00, 0, 1, 1, 32'hA4, 4));
    tbl.push_back(mk(1, 0, 32'h00, 0, 1, 0, 32'h00, 5));

    foreach (tbl[i]) begin
      v = '0; d = '0; f = '0;
      v[tbl[i].lane] = tbl[i].v;
      d[tbl[i].lane*DW +: DW] = tbl[i].d;
      f[tbl[i].lane] = tbl[i].f;
      drive(v, d, f, 1'b0);
      check_model();
      chk("tv_tready", tbl[i].lane, 64'(bus.s_axis_tready[tbl[i].lane]), 64'(tbl[i].e_rdy));
      chk("tv_wr_en", tbl[i].lane, 64'(bus.wr_en[tbl[i].lane]), 64'(tbl[i].e_wr));
      if (tbl[i].e_wr)
        chk("tv_data_in", tbl[i].lane, 64'(bus.data_in[tbl[i].lane*DW +: DW]), 64'(tbl[i].e_d));
      chk("tv_wr_count", tbl[i].lane, 64'(wr_count[tbl[i].lane*CW +: CW]), 64'(tbl[i].e_cnt));
      advance();
    end

    // Lane 2: 20 writes saturate the 4-bit counter; clear beats a same-cycle write
    for (int i = 0; i < 20; i++) begin
      d = '0;
      d[2*DW +: DW] = DW'(32'h200 + i);
      drive(4'b0100, d, '0, 1'b0);
      check_model();
      advance();
    end
    drive('0, '0, '0, 1'b1);
    check_model();
    chk("sat_count", 2, 64'(wr_count[2*CW +: CW]), 64'(15));
    chk("sat_last_write", 2, 64'(bus.wr_en[2]), 64'(1));
    advance();
    drive('0, '0, '0, 1'b0);
    check_model();
    chk("clr_priority", 2, 64'(wr_count[2*CW +: CW]), 64'(0));
    advance();

    // Random traffic on all lanes
    for (int k = 0; k < NCH; k++) begin m_acc[k] = 0; got[k] = 0; end
    done = 1'b0;
    for (int cyc = 0; cyc < 60000 && !done; cyc++) begin
      for (int k = 0; k < NCH; k++) begin
        v[k] = (m_acc[k] < NBEATS) && ($urandom_range(0, 99) < 70);
        f[k] = ($urandom_range(0, 99) < 35);
        d[k*DW +: DW] = DW'($urandom);
      end
      drive(v, d, f, $urandom_range(0, 63) == 0);
      check_model();
      advance();
      done = 1'b1;
      for (int k = 0; k < NCH; k++) if (m_acc[k] < NBEATS) done = 1'b0;
    end
    chk("random_timeout", -1, 64'(done), 64'(1));
    repeat (4) idle_cycle();
    for (int k = 0; k < NCH; k++) chk("written_vs_accepted", k, 64'(got[k]), 64'(m_acc[k]));

    // Lane 3: reset while holding two beats under fifo_full, then no stale write
    d = '0;
    d[3*DW +: DW] = DW'(32'h33);
    drive(4'b1000, d, 4'b1000, 1'b0);
    check_model();
    advance();
    d[3*DW +: DW] = DW'(32'h34);
    drive(4'b1000, d, 4'b1000, 1'b0);
    check_model();
    advance();
    drive('0, '0, 4'b1000, 1'b0);
    check_model();
    chk("two_held_tready", 3, 64'(bus.s_axis_tready[3]), 64'(0));
    bus.fifo_full = '0;
    cur_f = '0;
    rst_n = 1'b0;
    #1;
    chk("midrst_wr_en", 3, 64'(bus.wr_en[3]), 64'(0));
    chk("midrst_data_in", 3, 64'(bus.data_in[3*DW +: DW]), 64'(0));
    chk("midrst_tready", -1, 64'(bus.s_axis_tready), 64'(0));
    chk("midrst_wr_count", -1, 64'(wr_count), 64'(0));
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int k = 0; k < NCH; k++) got[k] = 0;
    repeat (4) idle_cycle();
    chk("no_stale_write", 3, 64'(got[3]), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
